// File: rtl/ex_muldiv_pkg.sv
// md_pkg: op and state encodings shared by ID decode, hazard unit, muldiv.
// Optional macro MD_MADD_EN enables madd/msub (ops 6/7).
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_CNT_W = 16;

  // True for ops that Start may launch in this build.
  function automatic logic md_is_launch(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      MD_MULT, MD_MULTU,
      MD_DIV, MD_DIVU: ok = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MSUB: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for ops that take the divide latency.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between EX issue and muldiv.
// master = issuing side, slave = muldiv unit.
interface ex_muldiv_if;

  logic        Start;
  logic [2:0]  Op;
  logic        WE;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, WE, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, Op, WE, A, B,
    output Busy, HI, LO
  );

endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle mult/div unit owning HI/LO.
// Optional macro MD_MADD_EN adds madd/msub accumulate into {HI,LO}.
module ex_muldiv
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       Clk,
  input logic       Reset,
  ex_muldiv_if.slave md
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [31:0]           a_q, a_d;
  logic [31:0]           b_q, b_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  logic                  launch;
  logic                  done;
  logic                  res_wr;
  logic [63:0]           res;

  logic signed [63:0]    prod_s;
  logic [63:0]           prod_u;
  logic [31:0]           div_b;
  logic [31:0]           abs_a;
  logic [31:0]           abs_b;
  logic [31:0]           uq;
  logic [31:0]           ur;
  logic [31:0]           sq;
  logic [31:0]           sr;
  logic [31:0]           udq;
  logic [31:0]           udr;

  assign launch = (state_q == MD_IDLE) && md.Start
                  && md_is_launch(md.Op);
  assign done   = (state_q == MD_BUSY)
                  && (cnt_q == MD_CNT_W'(1));

  // State, counter and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (launch) begin
          state_d = MD_BUSY;
          cnt_d   = md_is_div(md.Op)
                    ? MD_CNT_W'(DIV_CYCLES)
                    : MD_CNT_W'(MULT_CYCLES);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - MD_CNT_W'(1);
        if (done) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand capture, HI/LO writes and outputs.
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (launch) begin
      op_d = md.Op;
      a_d  = md.A;
      b_d  = md.B;
    end else if ((state_q == MD_IDLE) && !md.Start && md.WE) begin
      if (md.Op == MD_MTHI) hi_d = md.A;
      if (md.Op == MD_MTLO) lo_d = md.A;
    end
    if (done && res_wr) begin
      hi_d = res[63:32];
      lo_d = res[31:0];
    end
  end

  assign md.Busy = (state_q == MD_BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

  // Arithmetic on captured operands; division by magnitude.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q})
           * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    sq     = (a_q[31] ^ div_b[31]) ? (32'd0 - uq) : uq;
    sr     = a_q[31] ? (32'd0 - ur) : ur;
    udq    = a_q / div_b;
    udr    = a_q % div_b;
    res    = '0;
    res_wr = 1'b0;
    case (op_q)
      MD_MULT: begin
        res    = prod_s;
        res_wr = 1'b1;
      end
      MD_MULTU: begin
        res    = prod_u;
        res_wr = 1'b1;
      end
      MD_DIV: begin
        res    = {sr, sq};
        res_wr = (b_q != 32'd0);
      end
      MD_DIVU: begin
        res    = {udr, udq};
        res_wr = (b_q != 32'd0);
      end
`ifdef MD_MADD_EN
      MD_MADD: begin
        res    = {hi_q, lo_q} + prod_s;
        res_wr = 1'b1;
      end
      MD_MSUB: begin
        res    = {hi_q, lo_q} - prod_s;
        res_wr = 1'b1;
      end
`endif
      default: begin
        res    = '0;
        res_wr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: vector table plus corner sequences for ex_muldiv.
// Covers both builds of MD_MADD_EN.
module tb_ex_muldiv;
  import md_pkg::*;

  logic Clk;
  logic Reset;

  ex_muldiv_if mif ();

  ex_muldiv #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .md   (mif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic we_write(logic [2:0] op, logic [31:0] a);
    mif.WE = 1'b1;
    mif.Op = op;
    mif.A  = a;
    @(negedge Clk);
    mif.WE = 1'b0;
  endtask

  task automatic run_op(string nm, logic [2:0] op,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] ehi, logic [31:0] elo,
                        int ecyc, bit intf);
    exp_t        e;
    int          cyc;
    bit          held;
    logic [31:0] h0;
    logic [31:0] l0;
    sb.push_back('{ehi, elo, ecyc});
    h0 = mif.HI;
    l0 = mif.LO;
    mif.Start = 1'b1;
    mif.Op    = op;
    mif.A     = a;
    mif.B     = b;
    @(negedge Clk);
    mif.Start = 1'b0;
    cyc  = 0;
    held = 1'b1;
    while (mif.Busy && cyc < 200) begin
      if (mif.HI !== h0 || mif.LO !== l0) held = 1'b0;
      mif.A = $urandom;
      mif.B = $urandom;
      if (intf && cyc == 2) begin
        mif.Start = 1'b1;
        mif.Op    = MD_MULT;
      end else if (intf && cyc == 3) begin
        mif.Start = 1'b0;
        mif.WE    = 1'b1;
        mif.Op    = MD_MTHI;
        mif.A     = 32'h55;
      end else begin
        mif.Start = 1'b0;
        mif.WE    = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    mif.Start = 1'b0;
    mif.WE    = 1'b0;
    e = sb.pop_front();
    chk({nm, " cycles"}, 64'(cyc), 64'(e.cyc));
    chk({nm, " hold"}, 64'(held), 64'd1);
    chk({nm, " HI"}, 64'(mif.HI), 64'(e.hi));
    chk({nm, " LO"}, 64'(mif.LO), 64'(e.lo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,
                32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,
                32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, 10};
    vecs[4] = '{MD_DIVU,  32'd100, 32'd7,
                32'd2, 32'd14, 10};
    vecs[5] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{MD_DIV,   32'd7, 32'hFFFFFFFE,
                32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,
                32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[9] = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD,
                32'hFFFFFFFE, 32'h00000002, 10};

    Reset     = 1'b1;
    mif.Start = 1'b0;
    mif.WE    = 1'b0;
    mif.Op    = '0;
    mif.A     = '0;
    mif.B     = '0;
    repeat (2) @(negedge Clk);
    chk("rst Busy", 64'(mif.Busy), 64'd0);
    chk("rst HI", 64'(mif.HI), 64'd0);
    chk("rst LO", 64'(mif.LO), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op,
             vecs[i].a, vecs[i].b, vecs[i].hi,
             vecs[i].lo, vecs[i].cyc, 1'b0);
    end

    we_write(MD_MTHI, 32'h11);
    chk("mthi Busy", 64'(mif.Busy), 64'd0);
    chk("mthi HI", 64'(mif.HI), 64'h11);
    we_write(MD_MTLO, 32'h22);
    chk("mtlo LO", 64'(mif.LO), 64'h22);
    chk("mtlo HI", 64'(mif.HI), 64'h11);
    run_op("divu0", MD_DIVU, 32'd5, 32'd0,
           32'h11, 32'h22, 10, 1'b0);
    run_op("div0", MD_DIV, 32'd9, 32'd0,
           32'h11, 32'h22, 10, 1'b0);

    run_op("div_intf", MD_DIV, 32'd100, 32'd7,
           32'd2, 32'd14, 10, 1'b1);

    mif.Start = 1'b1;
    mif.Op    = MD_MULT;
    mif.A     = 32'd3;
    mif.B     = 32'd5;
    @(negedge Clk);
    mif.Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort Busy", 64'(mif.Busy), 64'd0);
    chk("abort HI", 64'(mif.HI), 64'd0);
    chk("abort LO", 64'(mif.LO), 64'd0);
    run_op("after_rst", MD_MULTU, 32'd3, 32'd4,
           32'd0, 32'd12, 5, 1'b0);

    mif.Start = 1'b1;
    mif.WE    = 1'b1;
    mif.Op    = MD_MTHI;
    mif.A     = 32'h77;
    @(negedge Clk);
    mif.Start = 1'b0;
    mif.WE    = 1'b0;
    chk("start_we Busy", 64'(mif.Busy), 64'd0);
    chk("start_we HI", 64'(mif.HI), 64'd0);

    mif.Start = 1'b1;
    mif.Op    = MD_MTLO;
    @(negedge Clk);
    mif.Start = 1'b0;
    chk("unused5 Busy", 64'(mif.Busy), 64'd0);
    chk("unused5 LO", 64'(mif.LO), 64'd12);

`ifdef MD_MADD_EN
    we_write(MD_MTHI, 32'h0);
    we_write(MD_MTLO, 32'hFFFFFFFF);
    run_op("madd", MD_MADD, 32'd1, 32'd1,
           32'd1, 32'd0, 5, 1'b0);
    run_op("msub", MD_MSUB, 32'd2, 32'd1,
           32'd0, 32'hFFFFFFFE, 5, 1'b0);
`else
    mif.Start = 1'b1;
    mif.Op    = MD_MADD;
    mif.A     = 32'd1;
    mif.B     = 32'd1;
    @(negedge Clk);
    mif.Start = 1'b0;
    chk("op6 Busy", 64'(mif.Busy), 64'd0);
    @(negedge Clk);
    chk("op6 Busy2", 64'(mif.Busy), 64'd0);
    chk("op6 LO", 64'(mif.LO), 64'd12);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
